// File: rtl/hid_pkg.sv
// Shared types for the HID report merge path: device type codes and the FIFO entry layout.
package hid_pkg;

  localparam int HID_W  = 64;
  // Wide enough for the largest supported port count (8).
  localparam int PORT_W = 3;

  typedef enum logic [1:0] {
    TYP_NONE  = 2'd0,
    TYP_KBD   = 2'd1,
    TYP_MOUSE = 2'd2,
    TYP_GAME  = 2'd3
  } hid_typ_e;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [1:0]        typ;
    logic [HID_W-1:0]  data;
  } hid_entry_t;

  localparam int ENTRY_W = $bits(hid_entry_t);

endpackage

// File: rtl/hid_fwft_fifo.sv
// First-word-fall-through FIFO with occupancy output; head reads as zero while empty.
module hid_fwft_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic [AW:0]  level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/hid_report_arbiter.sv
// Merges per-port HID report strobes into one ordered stream: holding slots, round-robin
// arbiter into a FWFT FIFO, activity LED stretchers and a saturating drop counter.
module hid_report_arbiter
  import hid_pkg::*;
#(
  parameter int NPORTS     = 2,
  parameter int DEPTH      = 8,
  parameter int ACT_CYCLES = 1200000,
  parameter int DROPW      = 8,
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int CW = (ACT_CYCLES > 1) ? $clog2(ACT_CYCLES) : 1
) (
  input  logic                  usbclk,
  input  logic                  usbrst_n,
  input  logic [2*NPORTS-1:0]   in_typ,
  input  logic [NPORTS-1:0]     in_report,
  input  logic [NPORTS-1:0]     in_conerr,
  input  logic [64*NPORTS-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PW-1:0]         out_port,
  output logic [1:0]            out_typ,
  output logic [63:0]           out_data,
  output logic [LW-1:0]         fifo_level,
  output logic [DROPW-1:0]      drop_cnt,
  output logic [NPORTS-1:0]     led_activity
);

  localparam int SW = DROPW + 4;

  logic [1:0] rst_sync_q;
  logic       rst_n;

  logic [NPORTS-1:0]             slot_vld_q, slot_vld_d;
  logic [NPORTS-1:0][1:0]        slot_typ_q, slot_typ_d;
  logic [NPORTS-1:0][HID_W-1:0]  slot_data_q, slot_data_d;
  logic [NPORTS-1:0][CW-1:0]     act_q, act_d;
  logic [PW-1:0]                 rr_q, rr_d;
  logic [DROPW-1:0]              drop_cnt_q, drop_cnt_d;

  logic [NPORTS-1:0] accept, lost, grant_hot, ovw;
  logic              pop, can_push, grant_vld, fifo_full;
  logic [PW-1:0]     grant_idx, cand;
  logic [SW-1:0]     drop_sum;
  hid_entry_t        push_entry, head;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) rst_sync_q <= '0;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      lost[i]   = in_conerr[i] || (in_typ[2*i +: 2] == TYP_NONE);
      accept[i] = in_report[i] && !lost[i];
    end
  end

  assign pop      = out_valid && out_ready;
  assign can_push = !fifo_full || pop;

  // First valid slot at or after rr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = PW'((int'(rr_q) + k) % NPORTS);
      if (can_push && !grant_vld && slot_vld_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_hot = grant_vld ? (NPORTS'(1) << grant_idx) : '0;
  assign rr_d      = grant_vld ? PW'((int'(grant_idx) + 1) % NPORTS) : rr_q;

  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_typ_d  = slot_typ_q;
    slot_data_d = slot_data_q;
    act_d       = act_q;
    ovw         = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (accept[i]) begin
        slot_vld_d[i]  = 1'b1;
        slot_typ_d[i]  = in_typ[2*i +: 2];
        slot_data_d[i] = in_data[HID_W*i +: HID_W];
        act_d[i]       = CW'(ACT_CYCLES - 1);
        // Reloading a slot that is leaving this cycle loses nothing.
        ovw[i]         = slot_vld_q[i] && !grant_hot[i];
      end else begin
        if (lost[i] || grant_hot[i]) slot_vld_d[i] = 1'b0;
        if (act_q[i] != '0)          act_d[i] = act_q[i] - CW'(1);
      end
    end
  end

  always_comb begin
    drop_sum = SW'(drop_cnt_q);
    for (int i = 0; i < NPORTS; i++) drop_sum = drop_sum + SW'(ovw[i]);
    drop_cnt_d = (drop_sum > SW'({DROPW{1'b1}})) ? {DROPW{1'b1}} : drop_sum[DROPW-1:0];
  end

  always_ff @(posedge usbclk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q  <= '0;
      slot_typ_q  <= '0;
      slot_data_q <= '0;
      act_q       <= '0;
      rr_q        <= '0;
      drop_cnt_q  <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_typ_q  <= slot_typ_d;
      slot_data_q <= slot_data_d;
      act_q       <= act_d;
      rr_q        <= rr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_comb begin
    push_entry.port = PORT_W'(grant_idx);
    push_entry.typ  = slot_typ_q[grant_idx];
    push_entry.data = slot_data_q[grant_idx];
  end

  hid_fwft_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (usbclk),
    .rst_n   (rst_n),
    .push_i  (grant_vld),
    .din_i   (push_entry),
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .dout_o  (head),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign out_port = head.port[PW-1:0];
  assign out_typ  = head.typ;
  assign out_data = head.data;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) led_activity[i] = (act_q[i] != '0);
  end

endmodule
